// File: rtl/sem_phase_timer.sv
// Traffic-light phase sequencer: prescaled TICK, per-phase duration table, start/stop/freeze/load.
// Optional pedestrian extension is compiled in when SEM_PED_EN is defined.
module sem_phase_timer #(
  parameter int unsigned CLK_DIV   = 12500000,
  parameter int unsigned DIV_WIDTH = 24,
  parameter int unsigned NPHASES   = 4,
  parameter int unsigned PH_WIDTH  = 2,
  parameter int unsigned CNT_WIDTH = 6,
  parameter int unsigned DEF_DUR   = 20
`ifdef SEM_PED_EN
  ,
  parameter int unsigned PED_PHASE = 0,
  parameter int unsigned PED_EXT   = 8
`endif
) (
  input  logic                 CLK,
  input  logic                 RSTn,
  input  logic                 CLK_ENA,
  input  logic                 GO,
  input  logic                 FREEZE,
  input  logic                 SEM_LOADn,
  input  logic [CNT_WIDTH-1:0] SEM_P,
  input  logic [PH_WIDTH-1:0]  PH_P,
  input  logic                 CFG_WE,
  input  logic [PH_WIDTH-1:0]  CFG_ADDR,
  input  logic [CNT_WIDTH-1:0] CFG_DATA,
`ifdef SEM_PED_EN
  input  logic                 PED_REQ,
  output logic                 PED_ACK,
`endif
  output logic [CNT_WIDTH-1:0] CUENTA,
  output logic [PH_WIDTH-1:0]  PHASE,
  output logic                 TICK,
  output logic                 PHASE_TC,
  output logic                 CYCLE_TC,
  output logic                 BUSY
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FROZEN
  } state_e;

  localparam logic [DIV_WIDTH-1:0] PRESC_LAST = DIV_WIDTH'(CLK_DIV - 1);
  localparam logic [PH_WIDTH-1:0]  LAST_PH    = PH_WIDTH'(NPHASES - 1);

  state_e                 state_q, state_d;
  logic [DIV_WIDTH-1:0]   presc_q, presc_d;
  logic [CNT_WIDTH-1:0]   cuenta_q, cuenta_d;
  logic [PH_WIDTH-1:0]    phase_q, phase_d;
  logic [CNT_WIDTH-1:0]   dur_q [NPHASES];
  logic [CNT_WIDTH-1:0]   dur_d [NPHASES];
  logic                   phase_tc_q, phase_tc_d;
  logic                   cycle_tc_q, cycle_tc_d;

  logic                   tick;
  logic                   end_ph;
  logic [CNT_WIDTH-1:0]   dur_eff;
  logic                   at_last;
  logic                   ph_p_ok;
  logic                   cfg_ok;

`ifdef SEM_PED_EN
  logic                   ped_flag_q, ped_flag_d;
  logic                   ped_ack_q, ped_ack_d;
  logic                   ext_q, ext_d;
  logic [CNT_WIDTH-1:0]   ext_cnt_q, ext_cnt_d;
  logic                   ped_hit;
`endif

  always_comb begin
    dur_eff = (dur_q[phase_q] == '0) ? CNT_WIDTH'(1) : dur_q[phase_q];
    at_last = (cuenta_q >= dur_eff - CNT_WIDTH'(1));
    ph_p_ok = (32'(PH_P) < NPHASES);
    cfg_ok  = CFG_WE && (32'(CFG_ADDR) < NPHASES);
    tick    = (state_q == ST_RUN) && GO && !FREEZE && (presc_q == PRESC_LAST);
  end

  always_comb begin
    state_d    = state_q;
    presc_d    = presc_q;
    cuenta_d   = cuenta_q;
    phase_d    = phase_q;
    dur_d      = dur_q;
    phase_tc_d = 1'b0;
    cycle_tc_d = 1'b0;
    end_ph     = 1'b0;
`ifdef SEM_PED_EN
    ped_flag_d = ped_flag_q | PED_REQ;
    ped_ack_d  = 1'b0;
    ext_d      = ext_q;
    ext_cnt_d  = ext_cnt_q;
    ped_hit    = (32'(phase_q) == PED_PHASE) && ped_flag_q && (PED_EXT != 0);
`endif

    if (cfg_ok) begin
      dur_d[CFG_ADDR] = CFG_DATA;
    end

    case (state_q)
      ST_IDLE: begin
        cuenta_d = '0;
        phase_d  = '0;
        presc_d  = '0;
`ifdef SEM_PED_EN
        ext_d     = 1'b0;
        ext_cnt_d = '0;
`endif
        if (GO) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        if (!GO) begin
          state_d  = ST_IDLE;
          cuenta_d = '0;
          phase_d  = '0;
          presc_d  = '0;
`ifdef SEM_PED_EN
          ext_d     = 1'b0;
          ext_cnt_d = '0;
`endif
        end else begin
          state_d = FREEZE ? ST_FROZEN : ST_RUN;
          // The prescaler only advances in RUN; the FROZEN->RUN edge still holds it.
          if ((state_q == ST_RUN) && !FREEZE) begin
            presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + DIV_WIDTH'(1);
          end
          if (!SEM_LOADn) begin
            cuenta_d = SEM_P;
            phase_d  = ph_p_ok ? PH_P : '0;
`ifdef SEM_PED_EN
            ext_d     = 1'b0;
            ext_cnt_d = '0;
`endif
          end else if (tick) begin
`ifdef SEM_PED_EN
            if (ext_q) begin
              if (ext_cnt_q <= CNT_WIDTH'(1)) begin
                end_ph    = 1'b1;
                ext_d     = 1'b0;
                ext_cnt_d = '0;
              end else begin
                ext_cnt_d = ext_cnt_q - CNT_WIDTH'(1);
                cuenta_d  = cuenta_q + CNT_WIDTH'(1);
              end
            end else if (at_last && ped_hit) begin
              // Extension replaces the normal phase end; a request in this cycle is kept.
              ext_d      = 1'b1;
              ext_cnt_d  = CNT_WIDTH'(PED_EXT);
              cuenta_d   = cuenta_q + CNT_WIDTH'(1);
              ped_ack_d  = 1'b1;
              ped_flag_d = PED_REQ;
            end else if (at_last) begin
              end_ph = 1'b1;
            end else begin
              cuenta_d = cuenta_q + CNT_WIDTH'(1);
            end
`else
            if (at_last) begin
              end_ph = 1'b1;
            end else begin
              cuenta_d = cuenta_q + CNT_WIDTH'(1);
            end
`endif
          end
        end
      end
    endcase

    if (end_ph) begin
      cuenta_d   = '0;
      phase_tc_d = 1'b1;
      if (phase_q == LAST_PH) begin
        phase_d    = '0;
        cycle_tc_d = 1'b1;
      end else begin
        phase_d = phase_q + PH_WIDTH'(1);
      end
    end

`ifdef SEM_PED_EN
    if (state_d == ST_IDLE) begin
      ped_flag_d = 1'b0;
    end
`endif
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_q    <= ST_IDLE;
      presc_q    <= '0;
      cuenta_q   <= '0;
      phase_q    <= '0;
      dur_q      <= '{default: CNT_WIDTH'(DEF_DUR)};
      phase_tc_q <= 1'b0;
      cycle_tc_q <= 1'b0;
`ifdef SEM_PED_EN
      ped_flag_q <= 1'b0;
      ped_ack_q  <= 1'b0;
      ext_q      <= 1'b0;
      ext_cnt_q  <= '0;
`endif
    end else if (CLK_ENA) begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      cuenta_q   <= cuenta_d;
      phase_q    <= phase_d;
      dur_q      <= dur_d;
      phase_tc_q <= phase_tc_d;
      cycle_tc_q <= cycle_tc_d;
`ifdef SEM_PED_EN
      ped_flag_q <= ped_flag_d;
      ped_ack_q  <= ped_ack_d;
      ext_q      <= ext_d;
      ext_cnt_q  <= ext_cnt_d;
`endif
    end
  end

  assign CUENTA   = cuenta_q;
  assign PHASE    = phase_q;
  assign TICK     = CLK_ENA & tick;
  assign PHASE_TC = CLK_ENA & phase_tc_q;
  assign CYCLE_TC = CLK_ENA & cycle_tc_q;
  assign BUSY     = (state_q != ST_IDLE);
`ifdef SEM_PED_EN
  assign PED_ACK  = CLK_ENA & ped_ack_q;
`endif

endmodule

// File: tb/tb_sem_phase_timer.sv
// Directed bench for sem_phase_timer: expectations queued per step, compared at the falling edge.
// Pedestrian checks are included when SEM_PED_EN is defined.
module tb_sem_phase_timer;

  logic       CLK = 1'b0;
  logic       RSTn, CLK_ENA, GO, FREEZE, SEM_LOADn, CFG_WE;
  logic [5:0] SEM_P, CFG_DATA;
  logic [1:0] PH_P, CFG_ADDR;
  logic [5:0] CUENTA;
  logic [1:0] PHASE;
  logic       TICK, PHASE_TC, CYCLE_TC, BUSY;
`ifdef SEM_PED_EN
  logic       PED_REQ, PED_ACK;
`endif

  sem_phase_timer #(
    .CLK_DIV(3), .DIV_WIDTH(2), .NPHASES(4), .PH_WIDTH(2), .CNT_WIDTH(6), .DEF_DUR(2)
`ifdef SEM_PED_EN
    , .PED_PHASE(0), .PED_EXT(3)
`endif
  ) dut (
    .CLK(CLK), .RSTn(RSTn), .CLK_ENA(CLK_ENA), .GO(GO), .FREEZE(FREEZE),
    .SEM_LOADn(SEM_LOADn), .SEM_P(SEM_P), .PH_P(PH_P),
    .CFG_WE(CFG_WE), .CFG_ADDR(CFG_ADDR), .CFG_DATA(CFG_DATA),
`ifdef SEM_PED_EN
    .PED_REQ(PED_REQ), .PED_ACK(PED_ACK),
`endif
    .CUENTA(CUENTA), .PHASE(PHASE), .TICK(TICK),
    .PHASE_TC(PHASE_TC), .CYCLE_TC(CYCLE_TC), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [5:0] c;
    logic [1:0] p;
    logic       tk;
    logic       ptc;
    logic       ctc;
    logic       busy;
    logic       ack;
  } obs_t;

  typedef struct {
    string tag;
    obs_t  exp;
  } exp_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;
  int   dur[4]  = '{2, 2, 2, 2};

  function automatic obs_t sample_obs();
    obs_t o;
    o.c    = CUENTA;
    o.p    = PHASE;
    o.tk   = TICK;
    o.ptc  = PHASE_TC;
    o.ctc  = CYCLE_TC;
    o.busy = BUSY;
`ifdef SEM_PED_EN
    o.ack  = PED_ACK;
`else
    o.ack  = 1'b0;
`endif
    return o;
  endfunction

  task automatic push(input string tag, input int c, input int p, input logic tk,
                      input logic ptc, input logic ctc, input logic busy, input logic ack);
    exp_t e;
    e.tag      = tag;
    e.exp.c    = 6'(c);
    e.exp.p    = 2'(p);
    e.exp.tk   = tk;
    e.exp.ptc  = ptc;
    e.exp.ctc  = ctc;
    e.exp.busy = busy;
    e.exp.ack  = ack;
    sb.push_back(e);
  endtask

  // Advance one clock and compare the DUT against the oldest queued expectation.
  task automatic cyc();
    exp_t e;
    obs_t o;
    @(negedge CLK);
    n_total = n_total + 1;
    if (sb.size() == 0) begin
      $error("FAIL scoreboard_empty: observed an output with no expectation queued");
    end else begin
      e = sb.pop_front();
      o = sample_obs();
      assert (o === e.exp) n_pass = n_pass + 1;
      else $error("FAIL %s: observed c=%0d p=%0d tick=%b ptc=%b ctc=%b busy=%b ack=%b expected c=%0d p=%0d tick=%b ptc=%b ctc=%b busy=%b ack=%b",
                  e.tag, o.c, o.p, o.tk, o.ptc, o.ctc, o.busy, o.ack,
                  e.exp.c, e.exp.p, e.exp.tk, e.exp.ptc, e.exp.ctc, e.exp.busy, e.exp.ack);
    end
  endtask

  // Phase/count reached after t completed ticks; ext_cycle selects which visit of phase 0
  // is stretched by the pedestrian extension (-1 for none).
  function automatic void sched(input int t, input int ext_cycle, output int ph, output int c);
    int  cyc_i;
    int  e;
    bit  done;
    ph    = 0;
    c     = t;
    cyc_i = 0;
    done  = 1'b0;
    while (!done) begin
      e = (dur[ph] == 0) ? 1 : dur[ph];
      if (ph == 0 && cyc_i == ext_cycle) e = e + 3;
      if (c >= e) begin
        c  = c - e;
        ph = ph + 1;
        if (ph == 4) begin
          ph    = 0;
          cyc_i = cyc_i + 1;
        end
      end else begin
        done = 1'b1;
      end
    end
  endfunction

  // n counts samples since the IDLE->RUN edge (n=1 shows prescaler 0).
  task automatic run_sample(input string tag, input int n, input int ext_cycle, input logic ack);
    int   t, ph, c;
    logic ended;
    t = (n - 1) / 3;
    sched(t, ext_cycle, ph, c);
    ended = ((n - 1) % 3 == 0) && (t > 0) && (c == 0);
    push(tag, c, ph, (n % 3 == 0), ended, ended && (ph == 0), 1'b1, ack);
    cyc();
  endtask

  task automatic idle_check(input string tag);
    push(tag, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1);
  end

  initial begin
    RSTn = 1'b0; CLK_ENA = 1'b1; GO = 1'b1; FREEZE = 1'b0; SEM_LOADn = 1'b1;
    SEM_P = '0; PH_P = '0; CFG_WE = 1'b0; CFG_ADDR = '0; CFG_DATA = '0;
`ifdef SEM_PED_EN
    PED_REQ = 1'b0;
`endif
    idle_check("reset");

    // Default table: tick every 3 clk, phase every 6 clk, CYCLE_TC after phase 3
    RSTn = 1'b1;
    for (int n = 1; n <= 50; n++) run_sample("run_default", n, -1, 1'b0);

    GO = 1'b0;
    idle_check("go_low_idle");
    SEM_LOADn = 1'b0; SEM_P = 6'd5; PH_P = 2'd2;
    idle_check("load_ignored_idle");
    SEM_LOADn = 1'b1;

    CFG_WE = 1'b1; CFG_ADDR = 2'd1; CFG_DATA = 6'd0;
    idle_check("cfg_write1");
    CFG_ADDR = 2'd2; CFG_DATA = 6'd5;
    idle_check("cfg_write2");
    CFG_WE = 1'b0;
    dur[1] = 0;
    dur[2] = 5;

    // Table {2,0,5,2}, with a freeze inserted after sample 8 (phase 1, prescaler 1)
    GO = 1'b1;
    for (int n = 1; n <= 8; n++) run_sample("run_table", n, -1, 1'b0);
    FREEZE = 1'b1;
    for (int i = 0; i < 10; i++) begin
      push("frozen_hold", 0, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      cyc();
    end
    FREEZE = 1'b0;
    push("freeze_release", 0, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc();
    for (int n = 9; n <= 15; n++) run_sample("run_after_freeze", n, -1, 1'b0);

    // Sample 15 shows phase 2, CUENTA 1, TICK high: load on that tick
    SEM_LOADn = 1'b0; SEM_P = 6'd1; PH_P = 2'd3;
    push("load_on_tick", 1, 3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc();
    SEM_LOADn = 1'b1;
    push("load_hold1", 1, 3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc();
    push("load_hold2", 1, 3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc();
    push("load_end_next_tick", 0, 0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    cyc();

    // Reset mid-phase with GO still high restores IDLE and the default table
    RSTn = 1'b0;
    idle_check("reset_mid_phase");
    RSTn = 1'b1;
    dur = '{2, 2, 2, 2};
    for (int n = 1; n <= 7; n++) run_sample("run_after_reset", n, -1, 1'b0);
    CLK_ENA = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push("clk_ena_hold", 0, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      cyc();
    end
    CLK_ENA = 1'b1;
    for (int n = 8; n <= 13; n++) run_sample("run_after_ena", n, -1, 1'b0);
    GO = 1'b0;
    idle_check("go_low_idle2");

`ifdef SEM_PED_EN
    // Request in phase 2 stretches the next phase 0 to 5 ticks; ACK follows tick 10
    GO = 1'b1;
    for (int n = 1; n <= 45; n++) begin
      PED_REQ = (n == 14);
      run_sample("run_ped", n, 1, (n == 31));
    end
    PED_REQ = 1'b0;
    GO = 1'b0;
    idle_check("go_low_idle3");
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
